// File: rtl/multiplicacion_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier subsystem.
// Provides the FSM state encoding and the product-width rule used by every file.
package multiplicacion_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/multiplicacion_ruta_datos.sv
// Datapath of the shift-add multiplier: shifted multiplicand, multiplier, accumulator
// and iteration counter, driven by load/step strobes from the controlling FSM.
module multiplicacion_ruta_datos
   import multiplicacion_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int PW = prod_w(WIDTH),
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] multiplicando_i,
   input  logic [WIDTH-1:0] multiplicador_i,
   output logic [PW-1:0]    acc_next_o,
   output logic             last_o
);

   logic [PW-1:0]    a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    acc_sum;

   // acc_sum is the accumulator after the current iteration; the FSM captures it
   // into the result register on the last iteration without waiting an extra cycle.
   assign acc_sum    = b_q[0] ? (acc_q + a_q) : acc_q;
   assign acc_next_o = acc_sum;
   assign last_o     = (count_q == CW'(WIDTH - 1));

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      count_d = count_q;
      if (load_i) begin
         a_d     = {{(PW - WIDTH){1'b0}}, multiplicando_i};
         b_d     = multiplicador_i;
         acc_d   = '0;
         count_d = '0;
      end else if (step_i) begin
         acc_d   = acc_sum;
         a_d     = a_q << 1;
         b_d     = b_q >> 1;
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/subsistema_multiplicacion.sv
// Sequential unsigned multiplier feeding the display subsystem: start/ready handshake,
// fixed WIDTH-iteration calculation, one-cycle valid pulse and a held result bus.
module subsistema_multiplicacion
   import multiplicacion_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [WIDTH-1:0]           multiplicando,
   input  logic [WIDTH-1:0]           multiplicador,
   output logic                       ready,
   output logic                       busy,
   output logic                       valid,
   output logic [prod_w(WIDTH)-1:0]   resultados
);

   localparam int PW = prod_w(WIDTH);

   state_t        state_q, state_d;
   logic [PW-1:0] resultados_q, resultados_d;
   logic          load;
   logic          step;
   logic          last;
   logic [PW-1:0] acc_next;

   multiplicacion_ruta_datos #(
      .WIDTH(WIDTH)
   ) u_ruta_datos (
      .clk            (clk),
      .rst_n          (reset),
      .load_i         (load),
      .step_i         (step),
      .multiplicando_i(multiplicando),
      .multiplicador_i(multiplicador),
      .acc_next_o     (acc_next),
      .last_o         (last)
   );

   // The result register only moves on the edge entering DONE, so the display
   // consumer always sees a stable product between operations.
   always_comb begin
      state_d      = state_q;
      resultados_d = resultados_q;
      load         = 1'b0;
      step         = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (last) begin
               resultados_d = acc_next;
               state_d      = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         resultados_q <= '0;
      end else begin
         state_q      <= state_d;
         resultados_q <= resultados_d;
      end
   end

   assign ready      = (state_q == IDLE);
   assign busy       = (state_q == CALC);
   assign valid      = (state_q == DONE);
   assign resultados = resultados_q;

endmodule

// File: tb/tb_subsistema_multiplicacion.sv
// Self-checking bench for subsistema_multiplicacion: directed handshake scenarios plus
// random operand pairs, each product checked against plain A*B arithmetic.
module tb_subsistema_multiplicacion;

   localparam int WIDTH = 8;
   localparam int PW    = 2 * WIDTH;

   logic          clk;
   logic          reset;
   logic          start;
   logic [7:0]    multiplicando;
   logic [7:0]    multiplicador;
   logic          ready;
   logic          busy;
   logic          valid;
   logic [15:0]   resultados;

   int            compared;
   int            mismatched;
   int            validSeen;
   int            opsDone;
   logic [15:0]   lastProd;

   subsistema_multiplicacion #(
      .WIDTH(WIDTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicando(multiplicando),
      .multiplicador(multiplicador),
      .ready        (ready),
      .busy         (busy),
      .valid        (valid),
      .resultados   (resultados)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts valid pulses independently of the directed sequence; a one-cycle pulse
   // is seen on exactly one falling edge.
   always @(negedge clk) begin
      if (valid === 1'b1) validSeen++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: start low during CALC; 1: random start/operand noise; 2: start held with A=2,B=2
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int mode);
      logic [15:0] expProd;
      int waitCycles;
      expProd = 16'(a) * 16'(b);
      waitCycles = 0;
      while (ready !== 1'b1 && waitCycles < 50) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      checkOutput("readyBeforeStart", 32'(ready), 32'd1);
      start = 1'b1;
      multiplicando = a;
      multiplicador = b;
      @(posedge clk); #1;
      for (int c = 1; c <= WIDTH; c++) begin
         if (mode == 2) begin
            start = 1'b1;
            multiplicando = 8'd2;
            multiplicador = 8'd2;
         end else if (mode == 1) begin
            start = 1'($urandom);
            multiplicando = 8'($urandom);
            multiplicador = 8'($urandom);
         end else begin
            start = 1'b0;
            multiplicando = 8'($urandom);
            multiplicador = 8'($urandom);
         end
         checkOutput("busyInCalc", 32'(busy), 32'd1);
         checkOutput("validEarly", 32'(valid), 32'd0);
         checkOutput("resultHold", 32'(resultados), 32'(lastProd));
         @(posedge clk); #1;
      end
      checkOutput("validPulse", 32'(valid), 32'd1);
      checkOutput("product", 32'(resultados), 32'(expProd));
      checkOutput("readyInDone", 32'(ready), 32'd0);
      lastProd = expProd;
      opsDone++;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("validOneCycle", 32'(valid), 32'd0);
      checkOutput("readyReturn", 32'(ready), 32'd1);
      checkOutput("resultAfter", 32'(resultados), 32'(lastProd));
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         checkOutput("idleReady", 32'(ready), 32'd1);
         checkOutput("idleValid", 32'(valid), 32'd0);
         checkOutput("idleHold", 32'(resultados), 32'(lastProd));
      end
   endtask

   task automatic resetMidOp(input logic [7:0] a, input logic [7:0] b, input int iters);
      start = 1'b1;
      multiplicando = a;
      multiplicador = b;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < iters; i++) begin
         @(posedge clk); #1;
      end
      #2;
      reset = 1'b0;
      #1;
      checkOutput("abortReady", 32'(ready), 32'd1);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortValid", 32'(valid), 32'd0);
      checkOutput("abortResult", 32'(resultados), 32'd0);
      lastProd = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      idleCycles(WIDTH + 2);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      validSeen  = 0;
      opsDone    = 0;
      lastProd   = '0;
      start         = 1'b0;
      multiplicando = '0;
      multiplicador = '0;
      reset         = 1'b0;

      @(posedge clk); #1;
      checkOutput("resetReady", 32'(ready), 32'd1);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetValid", 32'(valid), 32'd0);
      checkOutput("resetResult", 32'(resultados), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      idleCycles(2);

      applyStimulus(8'd5, 8'd3, 0);
      applyStimulus(8'hFF, 8'hFF, 0);
      applyStimulus(8'h00, 8'hAA, 0);
      idleCycles(1);

      applyStimulus(8'd7, 8'd9, 2);
      applyStimulus(8'd12, 8'd12, 0);
      idleCycles(2);

      resetMidOp(8'hAA, 8'h55, 4);
      applyStimulus(8'hAA, 8'h55, 0);

      for (int k = 0; k < 20; k++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (k == 3) ra = 8'h00;
         if (k == 7) rb = 8'hFF;
         applyStimulus(ra, rb, int'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 3)));
      end

      @(posedge clk); #1;
      checkOutput("validCount", 32'(validSeen), 32'(opsDone));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
